// File: rtl/i281_dump_pkg.sv
// rtl/i281_dump_pkg.sv - shared types and sizes for the i281 data-memory dump/preset blocks
package i281_dump_pkg;

    localparam int DUMP_DEPTH = 16;
    localparam int DUMP_WIDTH = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_DONE    = 3'd4
    } dump_state_t;

endpackage

// File: rtl/user_data_dump.sv
// rtl/user_data_dump.sv - walks the i281 data memory and streams each byte out with a running checksum
module user_data_dump
    import i281_dump_pkg::*;
#(
    parameter int DEPTH  = DUMP_DEPTH,
    parameter int WIDTH  = DUMP_WIDTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WIDTH-1:0]  mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              done,
    output logic [WIDTH-1:0]  checksum
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    dump_state_t       state;
    logic [ADDR_W-1:0] idx;

    // Read strobe is a pure decode of registered state, so no input reaches it combinationally.
    assign mem_rd_en = (state == S_READ);
    assign mem_addr  = idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (start) begin
                        state    <= S_READ;
                        checksum <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_READ: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    out_data  <= mem_rd_data;
                    out_index <= idx;
                    out_last  <= (idx == LAST_IDX);
                    out_valid <= 1'b1;
                    state     <= S_SEND;
                end
                S_SEND: begin
                    // Without a handshake everything holds, which keeps out_* stable through stalls.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        checksum  <= checksum + out_data;
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_user_data_dump.sv
// tb/tb_user_data_dump.sv - scoreboard bench for user_data_dump with a synchronous-read memory model
module tb_user_data_dump;
    import i281_dump_pkg::*;

    localparam int D  = DUMP_DEPTH;
    localparam int W  = DUMP_WIDTH;
    localparam int AW = $clog2(D);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          done;
    logic [W-1:0]  checksum;

    user_data_dump dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int data;
        int last;
    } xfer_t;
    typedef struct {
        int due;
        int sum;
    } done_t;

    xfer_t exp_q[$];
    done_t done_q[$];

    int errors = 0;
    int checks = 0;
    int stalls = 0;
    int xfers  = 0;
    int dones  = 0;
    int ready_mode = 0;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    // Monitor: pops the scoreboard on every handshake and on every done pulse.
    bit           prev_stall = 0;
    logic [W-1:0] prev_data;
    logic [AW-1:0] prev_index;
    logic         prev_last;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", int'(out_valid), 1);
                    check("stall_data", int'(out_data), int'(prev_data));
                    check("stall_index", int'(out_index), int'(prev_index));
                    check("stall_last", int'(out_last), int'(prev_last));
                end
                if (out_valid && out_ready) begin
                    xfers++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer: got index %0d with empty scoreboard", out_index);
                    end else begin
                        xfer_t e;
                        e = exp_q.pop_front();
                        check("xfer_index", int'(out_index), e.idx);
                        check("xfer_data", int'(out_data), e.data);
                        check("xfer_last", int'(out_last), e.last);
                    end
                end
                if (out_valid && !out_ready) stalls++;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_index = out_index;
                prev_last  = out_last;
                if (done) begin
                    dones++;
                    if (done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done at cycle %0d, none expected", cyc);
                    end else begin
                        done_t d;
                        d = done_q.pop_front();
                        check("done_cycle", cyc, d.due + stalls);
                        check("checksum", int'(checksum), d.sum);
                        check("busy_at_done", int'(busy), 0);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'(($urandom_range(0, 1)));
            endcase
        end
    end

    task automatic issue_start();
        int sum;
        @(posedge clk);
        #1;
        start  = 1'b1;
        stalls = 0;
        sum    = 0;
        for (int i = 0; i < D; i++) begin
            exp_q.push_back('{idx: i, data: int'(mem[i]), last: (i == D - 1) ? 1 : 0});
            sum += int'(mem[i]);
        end
        done_q.push_back('{due: cyc + 49, sum: sum % 256});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL dump_timeout: %0d transfers and %0d dones still pending", exp_q.size(), done_q.size());
            exp_q.delete();
            done_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic load_preset();
        int vals[D] = '{7, 3, 2, 1, 6, 4, 5, 8, 7, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < D; i++) mem[i] = W'(vals[i]);
    endtask

    initial begin
        int x0, d0, n;
        rst       = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < D; i++) mem[i] = '0;
        #3 rst = 1'b1;
        #4;
        check("rst_busy", int'(busy), 0);
        check("rst_rd_en", int'(mem_rd_en), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_index", int'(out_index), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_done", int'(done), 0);
        check("rst_checksum", int'(checksum), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Preset array, always ready
        load_preset();
        ready_mode = 0;
        issue_start();
        wait_idle();

        // Sorted result in the first eight bytes
        for (int i = 0; i < D; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) mem[i] = W'(i + 1);
        mem[8] = 8'd7;
        issue_start();
        wait_idle();

        // Checksum wrap
        for (int i = 0; i < D; i++) mem[i] = 8'hFF;
        issue_start();
        wait_idle();

        // Toggled backpressure on the preset
        load_preset();
        ready_mode = 1;
        issue_start();
        wait_idle();

        // Random contents, random backpressure
        ready_mode = 2;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < D; i++) mem[i] = W'($urandom_range(0, 255));
            issue_start();
            wait_idle();
        end

        // Start while busy and in the DONE cycle must be ignored
        ready_mode = 0;
        @(posedge clk);
        load_preset();
        x0 = xfers;
        d0 = dones;
        issue_start();
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (37) @(posedge clk);
        #1;
        check("done_cycle_probe", int'(done), 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        repeat (10) @(posedge clk);
        #1;
        check("ignored_start_xfers", xfers - x0, 16);
        check("ignored_start_dones", dones - d0, 1);
        check("ignored_start_busy", int'(busy), 0);

        // Asynchronous reset during SEND of index 5, then a clean restart
        load_preset();
        issue_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_index == 5) && n < 100);
        check("reached_index5", int'(out_valid && out_index == 5), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_rd_en", int'(mem_rd_en), 0);
        check("arst_addr", int'(mem_addr), 0);
        check("arst_valid", int'(out_valid), 0);
        check("arst_data", int'(out_data), 0);
        check("arst_index", int'(out_index), 0);
        check("arst_last", int'(out_last), 0);
        check("arst_done", int'(done), 0);
        check("arst_checksum", int'(checksum), 0);
        exp_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        issue_start();
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
